// File: rtl/field_counter_pkg.sv
// Shared types and helpers for the field counter bank and its button front end.
package field_counter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HOLD   = 2'd1,
      ST_REPEAT = 2'd2
   } fsm_state_e;

   typedef enum logic [1:0] {
      DIR_NONE = 2'd0,
      DIR_UP   = 2'd1,
      DIR_DOWN = 2'd2
   } dir_e;

   // Timer must hold both HOLD_CYC-1 and REP_CYC-1.
   function automatic int timer_width(input int hold_cyc, input int rep_cyc);
      int wh;
      int wr;
      wh = $clog2(hold_cyc);
      wr = $clog2(rep_cyc);
      return (wh > wr) ? wh : wr;
   endfunction

endpackage

// File: rtl/press_repeat_fsm.sv
// Button edge detection plus hold-to-repeat sequencing for the field counter bank.
// Emits a combinational step request so the first step lands on the press edge.
//
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   ST_IDLE   | waiting for a fresh press of up or down while enabled
//   ST_HOLD   | first step done, counting HOLD_CYC before auto-repeat starts
//   ST_REPEAT | auto-repeating, one step every REP_CYC cycles
module press_repeat_fsm
   import field_counter_pkg::*;
#(
   parameter int SW       = 2,
   parameter int HOLD_CYC = 8,
   parameter int REP_CYC  = 4
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          en_i,
   input  logic          force_idle_i,
   input  logic [SW-1:0] sel_i,
   input  logic          up_i,
   input  logic          down_i,
   output logic          step_req_o,
   output logic [1:0]    dir_o
);

   localparam int            TW      = timer_width(HOLD_CYC, REP_CYC);
   localparam logic [TW-1:0] HOLD_LD = TW'(HOLD_CYC - 1);
   localparam logic [TW-1:0] REP_LD  = TW'(REP_CYC - 1);

   logic          up_q;
   logic          down_q;
   fsm_state_e    state_q;
   logic [TW-1:0] timer_q;
   dir_e          dir_q;
   logic [SW-1:0] sel_q;

   logic press_up;
   logic press_dn;
   logic both;
   logic held;
   logic keep;

   // Press detection, hold qualification and the step request for this cycle.
   always_comb begin
      press_up   = up_i & ~up_q;
      press_dn   = down_i & ~down_q;
      both       = up_i & down_i;
      held       = (dir_q == DIR_UP) ? up_i : down_i;
      // A rising opposite button shows up as both buttons high, so it drops us out too.
      keep       = en_i & ~both & held & (sel_i == sel_q);
      step_req_o = 1'b0;
      dir_o      = DIR_NONE;
      if (!force_idle_i) begin
         case (state_q)
            ST_IDLE: begin
               if (en_i && !both && (press_up || press_dn)) begin
                  step_req_o = 1'b1;
                  dir_o      = press_up ? DIR_UP : DIR_DOWN;
               end
            end
            ST_HOLD, ST_REPEAT: begin
               if (keep && (timer_q == '0)) begin
                  step_req_o = 1'b1;
                  dir_o      = dir_q;
               end
            end
            default: ;
         endcase
      end
   end

   // Edge registers, state and timer; edges are sampled every cycle regardless of en.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         up_q    <= 1'b0;
         down_q  <= 1'b0;
         state_q <= ST_IDLE;
         timer_q <= '0;
         dir_q   <= DIR_NONE;
         sel_q   <= '0;
      end else begin
         up_q   <= up_i;
         down_q <= down_i;
         if (force_idle_i) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (step_req_o) begin
                     state_q <= ST_HOLD;
                     timer_q <= HOLD_LD;
                     dir_q   <= dir_e'(dir_o);
                     sel_q   <= sel_i;
                  end
               end
               ST_HOLD, ST_REPEAT: begin
                  if (!keep) begin
                     state_q <= ST_IDLE;
                     timer_q <= '0;
                  end else if (timer_q == '0) begin
                     state_q <= ST_REPEAT;
                     timer_q <= REP_LD;
                  end else begin
                     timer_q <= timer_q - TW'(1);
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
                  timer_q <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/field_counter_bank.sv
// Bank of NCH up/down field counters with per-field runtime limits, used by the
// time/date setting path. One shared button pair steps the selected field.
module field_counter_bank
   import field_counter_pkg::*;
#(
   parameter  int NCH      = 3,
   parameter  int W        = 7,
   parameter  int WRAP     = 1,
   parameter  int HOLD_CYC = 8,
   parameter  int REP_CYC  = 4,
   localparam int SW       = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic             clr_i,
   input  logic             load_en_i,
   input  logic [NCH*W-1:0] load_data_i,
   input  logic [NCH*W-1:0] limit_i,
   input  logic [SW-1:0]    sel_i,
   input  logic             up_i,
   input  logic             down_i,
   output logic [NCH*W-1:0] count_o,
   output logic [NCH-1:0]   wrap_pulse_o,
   output logic             step_pulse_o
);

   localparam logic [SW:0] NCH_V = (SW + 1)'(NCH);

   logic [W-1:0]   cnt_q [NCH];
   logic [W-1:0]   cnt_d [NCH];
   logic [NCH-1:0] wrap_q;
   logic [NCH-1:0] wrap_d;
   logic           step_q;
   logic           step_d;

   logic           step_req;
   logic [1:0]     dir;
   logic           sel_ok;
   logic           step_ok;
   logic [W-1:0]   lim_v;
   logic [W-1:0]   ld_v;
   logic [W:0]     nxt_v;

   press_repeat_fsm #(
      .SW       (SW),
      .HOLD_CYC (HOLD_CYC),
      .REP_CYC  (REP_CYC)
   ) u_fsm (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .en_i         (en_i),
      .force_idle_i (clr_i | load_en_i),
      .sel_i        (sel_i),
      .up_i         (up_i),
      .down_i       (down_i),
      .step_req_o   (step_req),
      .dir_o        (dir)
   );

   // Returns {wrapped, next value}; values above the limit collapse onto the limit.
   function automatic logic [W:0] step_field(input logic [W-1:0] cnt,
                                             input logic [W-1:0] lim,
                                             input logic         go_up);
      logic [W-1:0] nxt;
      logic         wr;
      nxt = cnt;
      wr  = 1'b0;
      if (go_up) begin
         if (cnt >= lim) begin
            if (WRAP != 0) begin
               nxt = '0;
               wr  = 1'b1;
            end else begin
               nxt = lim;
            end
         end else begin
            nxt = cnt + W'(1);
         end
      end else begin
         if (cnt == '0) begin
            if (WRAP != 0) begin
               nxt = lim;
               wr  = 1'b1;
            end
         end else if (cnt > lim) begin
            nxt = lim;
         end else begin
            nxt = cnt - W'(1);
         end
      end
      return {wr, nxt};
   endfunction

   // Per-field next value with clr > load > step priority.
   always_comb begin
      sel_ok  = ({1'b0, sel_i} < NCH_V);
      step_ok = step_req & sel_ok & ~clr_i & ~load_en_i;
      step_d  = step_ok;
      wrap_d  = '0;
      lim_v   = '0;
      ld_v    = '0;
      nxt_v   = '0;
      for (int i = 0; i < NCH; i++) begin
         lim_v    = limit_i[i*W +: W];
         ld_v     = load_data_i[i*W +: W];
         nxt_v    = step_field(cnt_q[i], lim_v, dir == DIR_UP);
         cnt_d[i] = cnt_q[i];
         if (clr_i) begin
            cnt_d[i] = '0;
         end else if (load_en_i) begin
            cnt_d[i] = (ld_v > lim_v) ? lim_v : ld_v;
         end else if (step_ok && (sel_i == SW'(i))) begin
            cnt_d[i]  = nxt_v[W-1:0];
            wrap_d[i] = nxt_v[W];
         end
      end
   end

   // Count registers and the registered step/wrap pulses aligned with the new count.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q  <= '{default: '0};
         wrap_q <= '0;
         step_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         wrap_q <= wrap_d;
         step_q <= step_d;
      end
   end

   for (genvar g = 0; g < NCH; g++) begin : g_out
      assign count_o[g*W +: W] = cnt_q[g];
   end

   assign wrap_pulse_o = wrap_q;
   assign step_pulse_o = step_q;

endmodule

// File: tb/tb_field_counter_bank.sv
// Directed bench for field_counter_bank: a wrapping build and a saturating build
// share the same stimulus; expected values are hand-computed.
module tb_field_counter_bank;

   localparam int          NCH      = 3;
   localparam int          W        = 7;
   localparam int          HOLD_CYC = 8;
   localparam int          REP_CYC  = 4;
   localparam logic [20:0] LIM      = {7'd23, 7'd59, 7'd59};

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        clr;
   logic        load_en;
   logic [20:0] load_data;
   logic [20:0] limit;
   logic [1:0]  sel;
   logic        up;
   logic        down;
   logic [20:0] count;
   logic [20:0] count_s;
   logic [2:0]  wrap;
   logic [2:0]  wrap_s;
   logic        step;
   logic        step_s;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   field_counter_bank #(.NCH(NCH), .W(W), .WRAP(1), .HOLD_CYC(HOLD_CYC), .REP_CYC(REP_CYC)) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .en_i(en), .clr_i(clr), .load_en_i(load_en),
      .load_data_i(load_data), .limit_i(limit), .sel_i(sel), .up_i(up), .down_i(down),
      .count_o(count), .wrap_pulse_o(wrap), .step_pulse_o(step)
   );

   field_counter_bank #(.NCH(NCH), .W(W), .WRAP(0), .HOLD_CYC(HOLD_CYC), .REP_CYC(REP_CYC)) u_sat (
      .clk_i(clk), .rst_ni(rst_n), .en_i(en), .clr_i(clr), .load_en_i(load_en),
      .load_data_i(load_data), .limit_i(limit), .sel_i(sel), .up_i(up), .down_i(down),
      .count_o(count_s), .wrap_pulse_o(wrap_s), .step_pulse_o(step_s)
   );

   typedef struct {
      logic        clr;
      logic        ld;
      logic        en;
      logic        up;
      logic        dn;
      logic [1:0]  sel;
      logic [20:0] ldata;
      logic [20:0] lim;
      logic [20:0] ecnt;
      logic [2:0]  ewrap;
      logic        estep;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [20:0] pk(input int f2, input int f1, input int f0);
      return {7'(f2), 7'(f1), 7'(f0)};
   endfunction

   function automatic vec_t mk(input logic c, input logic l, input logic e, input logic u,
                               input logic d, input logic [1:0] s, input logic [20:0] ldat,
                               input logic [20:0] lm, input logic [20:0] ec,
                               input logic [2:0] ew, input logic es);
      vec_t v;
      v.clr = c; v.ld = l; v.en = e; v.up = u; v.dn = d; v.sel = s;
      v.ldata = ldat; v.lim = lm; v.ecnt = ec; v.ewrap = ew; v.estep = es;
      return v;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      clr = 0; load_en = 0; up = 0; down = 0; en = 1; limit = LIM; load_data = '0;
   endtask

   initial begin
      int nsteps;
      logic exp_step;

      //          clr ld en up dn sel ldata            lim               expected count     wrap    step
      vecs.push_back(mk(0, 0, 1, 1, 0, 2, '0,             LIM,              pk(1, 0, 0),     3'b000, 1));
      vecs.push_back(mk(0, 0, 1, 0, 0, 2, '0,             LIM,              pk(1, 0, 0),     3'b000, 0));
      vecs.push_back(mk(0, 1, 1, 0, 0, 0, pk(5, 10, 70),  LIM,              pk(5, 10, 59),   3'b000, 0));
      vecs.push_back(mk(0, 1, 1, 0, 0, 0, pk(23, 0, 0),   LIM,              pk(23, 0, 0),    3'b000, 0));
      vecs.push_back(mk(0, 0, 1, 1, 0, 2, '0,             LIM,              pk(0, 0, 0),     3'b100, 1));
      vecs.push_back(mk(0, 0, 1, 0, 0, 2, '0,             LIM,              pk(0, 0, 0),     3'b000, 0));
      vecs.push_back(mk(0, 0, 1, 0, 1, 2, '0,             LIM,              pk(23, 0, 0),    3'b100, 1));
      vecs.push_back(mk(0, 0, 1, 0, 0, 2, '0,             LIM,              pk(23, 0, 0),    3'b000, 0));
      vecs.push_back(mk(0, 0, 1, 0, 1, 2, '0,             LIM,              pk(22, 0, 0),    3'b000, 1));
      vecs.push_back(mk(0, 0, 1, 0, 0, 2, '0,             LIM,              pk(22, 0, 0),    3'b000, 0));
      vecs.push_back(mk(0, 0, 1, 1, 1, 2, '0,             LIM,              pk(22, 0, 0),    3'b000, 0));
      vecs.push_back(mk(0, 0, 1, 0, 0, 2, '0,             LIM,              pk(22, 0, 0),    3'b000, 0));
      vecs.push_back(mk(0, 0, 1, 1, 0, 3, '0,             LIM,              pk(22, 0, 0),    3'b000, 0));
      vecs.push_back(mk(0, 0, 1, 0, 0, 3, '0,             LIM,              pk(22, 0, 0),    3'b000, 0));
      vecs.push_back(mk(0, 0, 1, 0, 1, 1, '0,             LIM,              pk(22, 59, 0),   3'b010, 1));
      vecs.push_back(mk(0, 0, 1, 0, 0, 1, '0,             LIM,              pk(22, 59, 0),   3'b000, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, '0,             LIM,              pk(22, 59, 0),   3'b000, 0));
      vecs.push_back(mk(0, 0, 1, 0, 0, 0, '0,             LIM,              pk(22, 59, 0),   3'b000, 0));
      vecs.push_back(mk(0, 0, 1, 0, 0, 0, '0,             pk(10, 59, 59),   pk(22, 59, 0),   3'b000, 0));
      vecs.push_back(mk(0, 0, 1, 0, 1, 2, '0,             pk(10, 59, 59),   pk(10, 59, 0),   3'b000, 1));
      vecs.push_back(mk(0, 0, 1, 0, 0, 2, '0,             LIM,              pk(10, 59, 0),   3'b000, 0));
      vecs.push_back(mk(1, 1, 1, 1, 0, 0, pk(1, 2, 3),    LIM,              pk(0, 0, 0),     3'b000, 0));
      vecs.push_back(mk(0, 0, 1, 0, 0, 0, '0,             LIM,              pk(0, 0, 0),     3'b000, 0));
      vecs.push_back(mk(0, 1, 1, 0, 0, 0, pk(1, 2, 3),    LIM,              pk(1, 2, 3),     3'b000, 0));
      vecs.push_back(mk(1, 0, 1, 0, 0, 0, '0,             LIM,              pk(0, 0, 0),     3'b000, 0));

      // reset state
      rst_n = 0;
      sel   = 0;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      check("rst count", 32'(count), 32'(pk(0, 0, 0)));
      check("rst wrap", 32'(wrap), 0);
      check("rst step", 32'(step), 0);
      check("rst count_sat", 32'(count_s), 32'(pk(0, 0, 0)));
      #3 rst_n = 1;

      // single-cycle vector table
      for (int k = 0; k < vecs.size(); k++) begin
         clr = vecs[k].clr; load_en = vecs[k].ld; en = vecs[k].en;
         up = vecs[k].up; down = vecs[k].dn; sel = vecs[k].sel;
         load_data = vecs[k].ldata; limit = vecs[k].lim;
         tick();
         check($sformatf("vec%0d count", k), 32'(count), 32'(vecs[k].ecnt));
         check($sformatf("vec%0d wrap", k), 32'(wrap), 32'(vecs[k].ewrap));
         check($sformatf("vec%0d step", k), 32'(step), 32'(vecs[k].estep));
      end
      idle_inputs();

      // hold up for 20 cycles on field 0: steps at 0, 8, 12, 16
      sel = 0; up = 1; nsteps = 0;
      for (int c = 0; c < 20; c++) begin
         exp_step = (c == 0) || (c >= HOLD_CYC && ((c - HOLD_CYC) % REP_CYC) == 0);
         if (exp_step) nsteps++;
         tick();
         check($sformatf("hold c%0d step", c), 32'(step), 32'(exp_step));
         check($sformatf("hold c%0d count", c), 32'(count), 32'(pk(0, 0, nsteps)));
      end
      up = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         check($sformatf("release c%0d step", c), 32'(step), 0);
         check($sformatf("release c%0d count", c), 32'(count), 32'(pk(0, 0, 4)));
      end

      // sel change mid-repeat stops stepping; only a new press steps the new field
      clr = 1; tick(); clr = 0;
      sel = 0; up = 1; nsteps = 0;
      for (int c = 0; c < 20; c++) begin
         if (c == 10) sel = 1;
         exp_step = (c == 0) || (c == 8);
         if (exp_step) nsteps++;
         tick();
         check($sformatf("selchg c%0d step", c), 32'(step), 32'(exp_step));
         check($sformatf("selchg c%0d count", c), 32'(count), 32'(pk(0, 0, nsteps)));
      end
      up = 0; tick();
      up = 1; tick();
      check("selchg newpress count", 32'(count), 32'(pk(0, 1, 2)));
      check("selchg newpress step", 32'(step), 1);
      up = 0; tick();

      // saturating build at both bounds
      load_en = 1; load_data = pk(23, 0, 59); tick(); load_en = 0;
      check("sat load", 32'(count_s), 32'(pk(23, 0, 59)));
      sel = 1; down = 1; tick();
      check("sat down@0 count", 32'(count_s), 32'(pk(23, 0, 59)));
      check("sat down@0 wrap", 32'(wrap_s), 0);
      down = 0; tick();
      sel = 0; up = 1; tick();
      check("sat up@lim f0 count", 32'(count_s), 32'(pk(23, 0, 59)));
      check("sat up@lim f0 wrap", 32'(wrap_s), 0);
      check("wrap up@lim f0 count", 32'(count[6:0]), 0);
      check("wrap up@lim f0 pulse", 32'(wrap), 32'(3'b001));
      up = 0; tick();
      sel = 2; up = 1; tick();
      check("sat up@lim f2 count", 32'(count_s), 32'(pk(23, 0, 59)));
      check("sat up@lim f2 wrap", 32'(wrap_s), 0);
      up = 0; tick();

      // async reset mid-repeat, button held through reset release
      clr = 1; tick(); clr = 0;
      sel = 0; up = 1;
      repeat (14) tick();
      check("pre-reset count", 32'(count), 32'(pk(0, 0, 3)));
      #3 rst_n = 0;
      #1;
      check("async rst count", 32'(count), 0);
      check("async rst count_sat", 32'(count_s), 0);
      check("async rst step", 32'(step), 0);
      @(posedge clk);
      #3 rst_n = 1;
      tick();
      check("held thru rst count", 32'(count), 32'(pk(0, 0, 1)));
      check("held thru rst step", 32'(step), 1);
      up = 0; tick();
      check("after rst release step", 32'(step), 0);
      check("after rst release count", 32'(count), 32'(pk(0, 0, 1)));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
